seg_scan: RTL and testbench

SEG_SCAN -- requirements
Module: seg_scan

---
 rtl/seg_scan_if.sv | 30 +++
 rtl/seg_scan.sv | 131 +++++++++++++
 tb/tb_seg_scan.sv | 194 +++++++++++++++++++
 3 files changed

// File: rtl/seg_scan_if.sv
// seg_scan_if: bundles the display-update handshake and the scanned display outputs.
//   DATA[15:0]  four hex nibbles, digit i shows DATA[4i+3:4i]
//   DP[3:0]     per-digit decimal point, active-high
//   BLANK[3:0]  per-digit blank, active-high
//   LOAD        update request, honoured only while READY=1
//   READY       a new LOAD can be accepted
//   FRAME       one-cycle pulse at frame wrap
//   SEG[7:0]    active-low segments, SEG[7]=dp, SEG[6:0]=g..a
//   DIG[3:0]    active-low digit enables, at most one low
// master = update source (drives DATA/DP/BLANK/LOAD), slave = seg_scan.
interface seg_scan_if;
  logic [15:0] DATA;
  logic [3:0]  DP;
  logic [3:0]  BLANK;
  logic        LOAD;
  logic        READY;
  logic        FRAME;
  logic [7:0]  SEG;
  logic [3:0]  DIG;

  modport master (
    output DATA, DP, BLANK, LOAD,
    input  READY, FRAME, SEG, DIG
  );

  modport slave (
    input  DATA, DP, BLANK, LOAD,
    output READY, FRAME, SEG, DIG
  );
endinterface

// File: rtl/seg_scan.sv
// seg_scan: 4-digit multiplexed 7-segment scanner with frame-synchronous,
// double-buffered display updates.
//   FPGA_CLK  sole clock, rising edge
//   FPGA_RST  asynchronous, active-high reset
//   bus       seg_scan_if.slave: DATA/DP/BLANK/LOAD in, READY/FRAME/SEG/DIG out
// Each digit slot lasts SCAN_DIV cycles; the first GUARD cycles of every slot
// drive all digits off to avoid ghosting. New data is latched into a shadow
// copy and only moved to the displayed copy on a FRAME cycle, so one frame
// never mixes old and new values.
module seg_scan #(
  parameter int unsigned SCAN_DIV = 12500,
  parameter int unsigned GUARD    = 16
) (
  input logic       FPGA_CLK,
  input logic       FPGA_RST,
  seg_scan_if.slave bus
);

  localparam int unsigned PW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [PW-1:0] TermCnt  = PW'(SCAN_DIV - 1);
  localparam logic [PW-1:0] GuardCnt = PW'(GUARD);

  logic [PW-1:0] presc_q, presc_d;
  logic [1:0]    idx_q, idx_d;
  logic [15:0]   act_data_q, act_data_d, sh_data_q, sh_data_d;
  logic [3:0]    act_dp_q, act_dp_d, sh_dp_q, sh_dp_d;
  logic [3:0]    act_blank_q, act_blank_d, sh_blank_q, sh_blank_d;
  logic          pending_q, pending_d;
  logic [7:0]    seg_q, seg_d;
  logic [3:0]    dig_q, dig_d;

  logic          tc, frame, load_acc;
  logic [3:0]    nib;
  logic [6:0]    seg7;

  always_comb begin
    tc       = (presc_q == TermCnt);
    frame    = tc && (idx_q == 2'd3);
    load_acc = bus.LOAD && !pending_q;

    presc_d = tc ? '0 : presc_q + 1'b1;
    idx_d   = tc ? idx_q + 2'd1 : idx_q;

    act_data_d  = act_data_q;
    act_dp_d    = act_dp_q;
    act_blank_d = act_blank_q;
    sh_data_d   = sh_data_q;
    sh_dp_d     = sh_dp_q;
    sh_blank_d  = sh_blank_q;
    pending_d   = pending_q;

    // Commit uses the pending value held before this edge; a LOAD on the same
    // FRAME cycle can only be accepted when nothing is pending, so it waits a frame.
    if (frame && pending_q) begin
      act_data_d  = sh_data_q;
      act_dp_d    = sh_dp_q;
      act_blank_d = sh_blank_q;
      pending_d   = 1'b0;
    end
    if (load_acc) begin
      sh_data_d  = bus.DATA;
      sh_dp_d    = bus.DP;
      sh_blank_d = bus.BLANK;
      pending_d  = 1'b1;
    end

    nib = act_data_q[{idx_q, 2'b00} +: 4];
    unique case (nib)
      4'h0: seg7 = 7'h40;
      4'h1: seg7 = 7'h79;
      4'h2: seg7 = 7'h24;
      4'h3: seg7 = 7'h30;
      4'h4: seg7 = 7'h19;
      4'h5: seg7 = 7'h12;
      4'h6: seg7 = 7'h02;
      4'h7: seg7 = 7'h78;
      4'h8: seg7 = 7'h00;
      4'h9: seg7 = 7'h10;
      4'hA: seg7 = 7'h08;
      4'hB: seg7 = 7'h03;
      4'hC: seg7 = 7'h46;
      4'hD: seg7 = 7'h21;
      4'hE: seg7 = 7'h06;
      default: seg7 = 7'h0E;
    endcase

    // Outputs are registered from the current scan state, so they lag it by one cycle.
    seg_d = 8'hFF;
    dig_d = 4'hF;
    if (presc_q >= GuardCnt) begin
      dig_d = ~(4'b0001 << idx_q);
      if (!act_blank_q[idx_q]) begin
        seg_d = {~act_dp_q[idx_q], seg7};
      end
    end
  end

  always_ff @(posedge FPGA_CLK or posedge FPGA_RST) begin
    if (FPGA_RST) begin
      presc_q     <= '0;
      idx_q       <= 2'd0;
      act_data_q  <= 16'h0;
      act_dp_q    <= 4'h0;
      act_blank_q <= 4'h0;
      sh_data_q   <= 16'h0;
      sh_dp_q     <= 4'h0;
      sh_blank_q  <= 4'h0;
      pending_q   <= 1'b0;
      seg_q       <= 8'hFF;
      dig_q       <= 4'hF;
    end else begin
      presc_q     <= presc_d;
      idx_q       <= idx_d;
      act_data_q  <= act_data_d;
      act_dp_q    <= act_dp_d;
      act_blank_q <= act_blank_d;
      sh_data_q   <= sh_data_d;
      sh_dp_q     <= sh_dp_d;
      sh_blank_q  <= sh_blank_d;
      pending_q   <= pending_d;
      seg_q       <= seg_d;
      dig_q       <= dig_d;
    end
  end

  assign bus.READY = ~pending_q;
  assign bus.FRAME = frame;
  assign bus.SEG   = seg_q;
  assign bus.DIG   = dig_q;

endmodule

// File: tb/tb_seg_scan.sv
// tb_seg_scan: randomized and directed stimulus for seg_scan (SCAN_DIV=8, GUARD=2),
// checked every cycle against a behavioural model derived from elapsed cycle count.
module tb_seg_scan;
  localparam int SD = 8;
  localparam int GD = 2;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  seg_scan_if bus ();

  seg_scan #(.SCAN_DIV(SD), .GUARD(GD)) dut (
    .FPGA_CLK(clk),
    .FPGA_RST(rst),
    .bus     (bus)
  );

  logic [7:0] seg_lut [16] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
                               8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E};

  int n_chk = 0;
  int n_err = 0;

  // Model state: cycles since reset release, displayed and queued frames.
  int          m_t;
  logic [15:0] ma_data, ms_data;
  logic [3:0]  ma_dp, ma_blank, ms_dp, ms_blank;
  bit          m_pend;
  logic [7:0]  m_seg;
  logic [3:0]  m_dig;

  logic [7:0]  obs_seg [4];
  bit          fr_seen;
  logic        last_ready;

  task automatic check_val(input string tag, input logic [15:0] act, input logic [15:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", tag, act, exp, $time);
    end
  endtask

  function automatic bit pred_frame();
    return ((m_t % SD) == SD - 1) && (((m_t / SD) % 4) == 3);
  endfunction

  task automatic model_reset();
    m_t = 0;
    ma_data = '0; ma_dp = '0; ma_blank = '0;
    ms_data = '0; ms_dp = '0; ms_blank = '0;
    m_pend = 1'b0;
    m_seg = 8'hFF;
    m_dig = 4'hF;
  endtask

  // One clock: check outputs at negedge, advance the model at posedge, return #1 after it.
  task automatic cycle();
    int presc, idx;
    bit fr, acc;
    logic [7:0] nseg;
    logic [3:0] ndig;
    @(negedge clk);
    presc = m_t % SD;
    idx   = (m_t / SD) % 4;
    fr    = pred_frame();
    check_val("ready", 16'(bus.READY), 16'(!m_pend));
    check_val("frame", 16'(bus.FRAME), 16'(fr));
    check_val("seg", 16'(bus.SEG), 16'(m_seg));
    check_val("dig", 16'(bus.DIG), 16'(m_dig));
    last_ready = bus.READY;
    if (bus.FRAME === 1'b1) fr_seen = 1'b1;
    for (int k = 0; k < 4; k++) begin
      if (bus.DIG === ~(4'b0001 << k)) obs_seg[k] = bus.SEG;
    end
    if (presc < GD) begin
      nseg = 8'hFF;
      ndig = 4'hF;
    end else begin
      ndig = ~(4'b0001 << idx);
      if (ma_blank[idx]) nseg = 8'hFF;
      else nseg = {~ma_dp[idx], seg_lut[ma_data[idx*4 +: 4]][6:0]};
    end
    acc = bus.LOAD && !m_pend;
    @(posedge clk);
    m_seg = nseg;
    m_dig = ndig;
    if (fr && m_pend) begin
      ma_data = ms_data; ma_dp = ms_dp; ma_blank = ms_blank;
      m_pend = 1'b0;
    end
    if (acc) begin
      ms_data = bus.DATA; ms_dp = bus.DP; ms_blank = bus.BLANK;
      m_pend = 1'b1;
    end
    m_t++;
    #1;
  endtask

  // Async reset asserted between edges; checks take effect before any clock edge.
  task automatic do_reset();
    #2 rst = 1'b1;
    #1;
    check_val("rst_seg", 16'(bus.SEG), 16'hFF);
    check_val("rst_dig", 16'(bus.DIG), 16'hF);
    check_val("rst_ready", 16'(bus.READY), 16'h1);
    check_val("rst_frame", 16'(bus.FRAME), 16'h0);
    model_reset();
    @(posedge clk);
    @(posedge clk);
    #1 rst = 1'b0;
    repeat (3) cycle();
    check_val("restart_dig0", 16'(bus.DIG), 16'(4'b1110));
  endtask

  task automatic wait_frame(input string tag);
    fr_seen = 1'b0;
    for (int i = 0; i < 80 && !fr_seen; i++) cycle();
    if (!fr_seen) check_val(tag, 16'h0, 16'h1);
  endtask

  task automatic capture_frame();
    for (int k = 0; k < 4; k++) obs_seg[k] = 8'h00;
    repeat (32) cycle();
  endtask

  initial begin
    int n_low;
    bus.DATA = '0; bus.DP = '0; bus.BLANK = '0; bus.LOAD = 1'b0;
    do_reset();
    repeat (40) cycle();

    // Accepted load followed by an ignored one; 1234 must appear.
    bus.DATA = 16'h1234; bus.DP = 4'h0; bus.BLANK = 4'h0; bus.LOAD = 1'b1;
    cycle();
    bus.DATA = 16'hFFFF; bus.DP = 4'hF;
    cycle();
    bus.LOAD = 1'b0;
    wait_frame("frame_timeout_a");
    capture_frame();
    check_val("d0_1234", 16'(obs_seg[0]), 16'h99);
    check_val("d1_1234", 16'(obs_seg[1]), 16'hB0);
    check_val("d2_1234", 16'(obs_seg[2]), 16'hA4);
    check_val("d3_1234", 16'(obs_seg[3]), 16'hF9);

    // Decimal point and blanking.
    bus.DATA = 16'h8F00; bus.DP = 4'b0001; bus.BLANK = 4'b1000; bus.LOAD = 1'b1;
    cycle();
    bus.LOAD = 1'b0;
    wait_frame("frame_timeout_b");
    capture_frame();
    check_val("d0_dp", 16'(obs_seg[0]), 16'h40);
    check_val("d1_0", 16'(obs_seg[1]), 16'hC0);
    check_val("d2_f", 16'(obs_seg[2]), 16'h8E);
    check_val("d3_blank", 16'(obs_seg[3]), 16'hFF);

    // LOAD on the FRAME cycle waits a full frame before committing.
    for (int i = 0; i < 40 && !pred_frame(); i++) cycle();
    bus.DATA = 16'($urandom); bus.DP = 4'($urandom); bus.BLANK = 4'h0; bus.LOAD = 1'b1;
    cycle();
    bus.LOAD = 1'b0;
    n_low = 0;
    last_ready = 1'b0;
    for (int i = 0; i < 80; i++) begin
      cycle();
      if (last_ready !== 1'b0) break;
      n_low++;
    end
    check_val("ready_low_cycles", 16'(n_low), 16'd32);

    // Reset while an update is pending discards it.
    bus.DATA = 16'hABCD; bus.LOAD = 1'b1;
    repeat (3) cycle();
    bus.LOAD = 1'b0;
    repeat (5) cycle();
    do_reset();
    repeat (40) cycle();

    // Random traffic.
    for (int i = 0; i < 600; i++) begin
      bus.DATA  = 16'($urandom);
      bus.DP    = 4'($urandom);
      bus.BLANK = 4'($urandom);
      bus.LOAD  = ($urandom_range(0, 5) == 0);
      cycle();
      if (i == 300) do_reset();
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
